// File: rtl/iter_divider.sv
// -----------------------------------------------------------------------------
// iter_divider
//   Multi-cycle integer divider (DIV/DIVU/REM/REMU) for the CPU core.
//   Restoring shift-subtract, one quotient bit per clock, DATA_WIDTH steps.
//   Signed operation divides magnitudes and fixes up signs on the final step:
//   the quotient is negative when operand signs differ, and the remainder
//   takes the sign of the dividend.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   in_valid      operands valid          in_ready   accepting (state IDLE)
//   dividend      numerator               divisor    denominator
//   is_signed     1: two's complement, 0: unsigned
//   out_valid     result valid (DONE)     out_ready  consumer takes result
//   quotient      result quotient         remainder  result remainder
//   div_by_zero   divisor was zero for this result
// -----------------------------------------------------------------------------
module iter_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic                  is_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_by_zero
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q,    state_d;
    logic [CW-1:0]   count_q,    count_d;
    logic [W-1:0]    rem_q,      rem_d;
    logic [W-1:0]    quo_q,      quo_d;
    logic [W-1:0]    dvsr_q,     dvsr_d;
    logic            neg_quo_q,  neg_quo_d;
    logic            neg_rem_q,  neg_rem_d;
    logic            dbz_q,      dbz_d;

    logic [W:0]      rem_shift;
    logic [W:0]      trial;
    logic [W-1:0]    step_rem;
    logic [W-1:0]    step_quo;

    function automatic logic [W-1:0] negate(input logic [W-1:0] val);
        return ~val + W'(1);
    endfunction

    // Magnitude of a two's-complement value; pass-through when unsigned.
    function automatic logic [W-1:0] magnitude(input logic [W-1:0] val, input logic en);
        return (en && val[W-1]) ? negate(val) : val;
    endfunction

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

    // Next-state and datapath: accept, restoring step with sign fix-up, handshake out.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;

        // The partial remainder is kept one bit wider during the trial so that
        // divisors with the top bit set still compare correctly.
        rem_shift = {rem_q, quo_q[W-1]};
        trial     = rem_shift - {1'b0, dvsr_q};
        if (!trial[W]) begin
            step_rem = trial[W-1:0];
            step_quo = {quo_q[W-2:0], 1'b1};
        end else begin
            step_rem = rem_shift[W-1:0];
            step_quo = {quo_q[W-2:0], 1'b0};
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    neg_quo_d = is_signed & (dividend[W-1] ^ divisor[W-1]);
                    neg_rem_d = is_signed & dividend[W-1];
                    if (divisor == {W{1'b0}}) begin
                        quo_d   = {W{1'b1}};
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        count_d = {CW{1'b0}};
                        state_d = S_DONE;
                    end else begin
                        quo_d   = magnitude(dividend, is_signed);
                        dvsr_d  = magnitude(divisor, is_signed);
                        rem_d   = {W{1'b0}};
                        dbz_d   = 1'b0;
                        count_d = CW'(W);
                        state_d = S_BUSY;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    quo_d   = neg_quo_q ? negate(step_quo) : step_quo;
                    rem_d   = neg_rem_q ? negate(step_rem) : step_rem;
                    state_d = S_DONE;
                end else begin
                    quo_d   = step_quo;
                    rem_d   = step_rem;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset that aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= {CW{1'b0}};
            rem_q     <= {W{1'b0}};
            quo_q     <= {W{1'b0}};
            dvsr_q    <= {W{1'b0}};
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
        end
    end

endmodule
